// File: rtl/display_staff_scroll_pkg.sv
// Shared display definitions: scroll FSM encoding and pixel layer indices.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package display_staff_scroll_pkg;

    typedef enum logic [1:0] {
        SCROLL_IDLE  = 2'd0,
        SCROLL_RUN   = 2'd1,
        SCROLL_PAUSE = 2'd2
    } scroll_state_t;

    localparam int LAYER_STAFF    = 0;
    localparam int LAYER_BAR      = 1;
    localparam int LAYER_PLAYHEAD = 2;
    localparam int LAYER_TICK     = 3;
    localparam int NUM_LAYERS     = 4;

endpackage

// File: rtl/display_staff_scroll_ctrl.sv
// Frame-rate scroll control: IDLE/RUN/PAUSE FSM, scroll position, beat pulse.
// Latency: state, scroll_px and beat_pulse update on the edge closing a frame_start/clear cycle.
// Backpressure: none; frame_start, run and clear are sampled every cycle.
module staff_scroll_ctrl
    import display_staff_scroll_pkg::*;
#(
    parameter int unsigned BEAT_PX_BITS       = 5,
    parameter int unsigned BEATS_PER_BAR_BITS = 2,
    parameter int unsigned BAR_PX_BITS        = BEAT_PX_BITS + BEATS_PER_BAR_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start_i,
    input  logic                   run_i,
    input  logic                   clear_i,
    output logic [BAR_PX_BITS-1:0] scroll_px_o,
    output logic                   beat_pulse_o
);

    scroll_state_t          state_q;
    logic [BAR_PX_BITS-1:0] scroll_px_q;
    logic [BAR_PX_BITS-1:0] scroll_px_d;
    logic                   beat_pulse_q;

    assign scroll_px_d = scroll_px_q + BAR_PX_BITS'(1);

    // The frame that stops a running scroll does not advance it, so a pause
    // freezes on the position that was on screen when run dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SCROLL_IDLE;
            scroll_px_q  <= '0;
            beat_pulse_q <= 1'b0;
        end else begin
            beat_pulse_q <= 1'b0;
            if (clear_i) begin
                state_q     <= SCROLL_IDLE;
                scroll_px_q <= '0;
            end else if (frame_start_i) begin
                case (state_q)
                    SCROLL_IDLE: begin
                        if (run_i) state_q <= SCROLL_RUN;
                    end
                    SCROLL_RUN: begin
                        if (run_i) begin
                            scroll_px_q  <= scroll_px_d;
                            beat_pulse_q <= (scroll_px_d[BEAT_PX_BITS-1:0] == '0);
                        end else begin
                            state_q <= SCROLL_PAUSE;
                        end
                    end
                    SCROLL_PAUSE: begin
                        if (run_i) state_q <= SCROLL_RUN;
                    end
                    default: state_q <= SCROLL_IDLE;
                endcase
            end
        end
    end

    assign scroll_px_o  = scroll_px_q;
    assign beat_pulse_o = beat_pulse_q;

endmodule

// File: rtl/display_staff_scroll.sv
// Scrolling music staff overlay: staff lines, bar lines, playhead (+ beat ticks with STAFF_BEAT_TICKS_EN).
// Latency: pixel outputs registered, valid 1 cycle after x/y; scroll state advances per frame_start.
// Backpressure: none; a new x/y pair is accepted every cycle.
module display_staff_scroll
    import display_staff_scroll_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH       = 0,
    parameter int unsigned SCREEN_HEIGHT      = 0,
    parameter int unsigned SCREEN_WIDTH_BITS  = 0,
    parameter int unsigned SCREEN_HEIGHT_BITS = 0,
    parameter int unsigned NUM_STAVES         = 1,
    parameter int unsigned LINE_THICKNESS     = 2,
    parameter int unsigned BEAT_PX_BITS       = 5,
    parameter int unsigned BEATS_PER_BAR_BITS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SCREEN_WIDTH_BITS-1:0]  x,
    input  logic [SCREEN_HEIGHT_BITS-1:0] y,
    input  logic                          frame_start,
    input  logic                          run,
    input  logic                          clear,
    output logic                          on,
    output logic                          staff_on,
    output logic                          bar_on,
    output logic                          playhead_on,
    output logic                          beat_pulse,
    output logic [BEATS_PER_BAR_BITS-1:0] beat_index
);

    localparam int unsigned BAR_PX_BITS = BEAT_PX_BITS + BEATS_PER_BAR_BITS;
    localparam int unsigned LINE_DIFF   = SCREEN_HEIGHT / (20 * NUM_STAVES);
    localparam int unsigned PLAYHEAD_X  = SCREEN_WIDTH >> 1;
    localparam int unsigned SUM_W       = (SCREEN_WIDTH_BITS + 1 > BAR_PX_BITS) ?
                                          SCREEN_WIDTH_BITS + 1 : BAR_PX_BITS;

    logic [BAR_PX_BITS-1:0] scroll_px;

    staff_scroll_ctrl #(
        .BEAT_PX_BITS       (BEAT_PX_BITS),
        .BEATS_PER_BAR_BITS (BEATS_PER_BAR_BITS),
        .BAR_PX_BITS        (BAR_PX_BITS)
    ) u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start),
        .run_i         (run),
        .clear_i       (clear),
        .scroll_px_o   (scroll_px),
        .beat_pulse_o  (beat_pulse)
    );

    assign beat_index = scroll_px[BAR_PX_BITS-1:BEAT_PX_BITS];

    // Power-of-two bar spacing turns the modulo into a low-bit slice.
    logic [SUM_W-1:0] x_scrolled;
    logic             bar_col;
    logic [31:0]      y_w;
    logic [31:0]      x_w;

    assign x_scrolled = SUM_W'(x) + SUM_W'(scroll_px);
    assign bar_col    = (x_scrolled[BAR_PX_BITS-1:0] == '0);
    assign y_w        = 32'(y);
    assign x_w        = 32'(x);

    logic [NUM_STAVES-1:0] staff_hit;
    logic [NUM_STAVES-1:0] span_hit;
`ifdef STAFF_BEAT_TICKS_EN
    logic [NUM_STAVES-1:0] tick_hit;
    logic                  beat_col;
    assign beat_col = (x_scrolled[BEAT_PX_BITS-1:0] == '0);
`endif

    for (genvar s = 0; s < NUM_STAVES; s++) begin : g_staff
        localparam int unsigned CENTRE = (2 * s + 1) * SCREEN_HEIGHT / (2 * NUM_STAVES);
        localparam int unsigned TOP    = CENTRE - 2 * LINE_DIFF;
        logic [4:0] line_hit;
        for (genvar k = 0; k < 5; k++) begin : g_line
            localparam int unsigned LINE_Y = TOP + k * LINE_DIFF;
            assign line_hit[k] = (y_w >= LINE_Y) && (y_w <= LINE_Y + LINE_THICKNESS - 1);
        end
        assign staff_hit[s] = |line_hit;
        assign span_hit[s]  = (y_w >= TOP) &&
                              (y_w <= CENTRE + 2 * LINE_DIFF + LINE_THICKNESS - 1);
`ifdef STAFF_BEAT_TICKS_EN
        assign tick_hit[s]  = (y_w >= CENTRE - LINE_DIFF / 2) &&
                              (y_w <= CENTRE + LINE_DIFF / 2);
`endif
    end

    logic [NUM_LAYERS-1:0] layer_d;
    logic [NUM_LAYERS-1:0] layer_q;
    logic                  on_q;

    always_comb begin
        layer_d                 = '0;
        layer_d[LAYER_STAFF]    = |staff_hit;
        layer_d[LAYER_BAR]      = bar_col && (|span_hit);
        layer_d[LAYER_PLAYHEAD] = (x_w == PLAYHEAD_X);
`ifdef STAFF_BEAT_TICKS_EN
        layer_d[LAYER_TICK]     = beat_col && !bar_col && (|tick_hit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q <= '0;
            on_q    <= 1'b0;
        end else begin
            layer_q <= layer_d;
            on_q    <= |layer_d;
        end
    end

    assign on          = on_q;
    assign staff_on    = layer_q[LAYER_STAFF];
    assign bar_on      = layer_q[LAYER_BAR];
    assign playhead_on = layer_q[LAYER_PLAYHEAD];

endmodule
